// File: rtl/rr_stream_arbiter_2_pkg.sv
// rtl/rr_stream_arbiter_2_pkg.sv - shared source ids and counter sizing for the 2-input stream arbiter
package rr_stream_arbiter_2_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Burst counter width; never narrower than one bit so BURST=1 still elaborates
  function automatic int cnt_width(input int burst);
    return (clog2(burst) < 1) ? 1 : clog2(burst);
  endfunction

endpackage

// File: rtl/rr_grant_2.sv
// rtl/rr_grant_2.sv - combinational round-robin grant with burst lock, one-hot {B,A}
module rr_grant_2
  import rr_stream_arbiter_2_pkg::*;
#(
  parameter int CW = 1
) (
  input  logic          a_valid,
  input  logic          b_valid,
  input  logic          owner,
  input  logic [CW-1:0] cnt,
  input  logic          load_en,
  output logic [1:0]    grant
);

  logic owner_valid;

  assign owner_valid = (owner == SRC_B) ? b_valid : a_valid;

  always_comb begin
    grant = 2'b00;
    if (load_en) begin
      if ((cnt != '0) && owner_valid) begin
        grant = (owner == SRC_B) ? 2'b10 : 2'b01;
      end else if (a_valid && b_valid) begin
        grant = (owner == SRC_B) ? 2'b01 : 2'b10;
      end else if (a_valid) begin
        grant = 2'b01;
      end else if (b_valid) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/rr_stream_arbiter_2.sv
// rtl/rr_stream_arbiter_2.sv - two-source round-robin stream arbiter with one registered output slot
module rr_stream_arbiter_2
  import rr_stream_arbiter_2_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  localparam int            CW        = cnt_width(BURST);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BURST - 1);
  localparam logic [CW-1:0] CNT_START = CW'((BURST > 1) ? 1 : 0);

  logic             owner;
  logic [CW-1:0]    cnt;
  logic             load_en;
  logic [1:0]       grant;
  logic             xfer;
  logic             xfer_src;
  logic [WIDTH-1:0] sel_data;

  // Slot may refill in the same cycle it drains
  assign load_en = !out_valid || out_ready;

  rr_grant_2 #(
    .CW(CW)
  ) u_grant (
    .a_valid (a_valid),
    .b_valid (b_valid),
    .owner   (owner),
    .cnt     (cnt),
    .load_en (load_en),
    .grant   (grant)
  );

  assign a_ready  = grant[0] & a_valid;
  assign b_ready  = grant[1] & b_valid;
  assign xfer     = a_ready | b_ready;
  assign xfer_src = b_ready ? SRC_B : SRC_A;
  assign sel_data = b_ready ? b_data : a_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_A;
      owner     <= SRC_B;
      cnt       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= xfer_src;
      owner     <= xfer_src;
      // Continue an active burst, otherwise start a fresh one for this source
      if ((xfer_src == owner) && (cnt != '0)) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end else begin
        cnt <= CNT_START;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rr_stream_arbiter_2.md
Name: rr_stream_arbiter_2

Overview:
Two-input round-robin stream arbiter with one registered output slot. It merges two valid/ready sources, A and B, into one output stream and records which source each beat came from. It sits directly upstream of the team's 2:1 selection stage: the registered grant (out_src) is the select for that stage, and out_data/out_valid feed the consumer behind it. Fairness is round-robin, with an optional burst lock that holds the grant on one source for several consecutive beats.

Parameters:
WIDTH, 8, data width of a_data/b_data/out_data
BURST, 1, maximum consecutive beats one source keeps the grant while the other also requests (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous and active-high
a_valid  input  1  source A has a beat
a_data  input  WIDTH  source A payload
a_ready  output  1  A beat accepted this cycle (combinational)
b_valid  input  1  source B has a beat
b_data  input  WIDTH  source B payload
b_ready  output  1  B beat accepted this cycle (combinational)
out_valid  output  1  output slot holds a beat
out_data  output  WIDTH  registered payload
out_src  output  1  registered origin of out_data: 0=A, 1=B (select for downstream mux)
out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_src=0.
  - owner=1 (B), so A wins the first contention.
  - cnt=0.
  - Takes effect immediately, mid-transfer included; the held beat is dropped.
- Load slot: load_en = !out_valid | out_ready. The slot accepts a new beat in the same cycle the old one drains (full throughput, no bubble).
- Grant (combinational, evaluated only when load_en=1):
  - If cnt!=0 and valid(owner): grant owner (burst lock).
  - Else if a_valid & b_valid: grant !owner.
  - Else if only one source is valid: grant that source.
  - Else: no grant.
- Ready outputs:
  - a_ready = load_en & grant==A & a_valid.
  - b_ready = load_en & grant==B & b_valid.
  - Never both high in the same cycle.
  - a_ready/b_ready must not depend on the same-side valid in a way that creates a loop. Valid-in-ready is allowed; the sources must not wait on ready before asserting valid.
- Transfer from source s (s_valid & s_ready):
  - Next edge: out_data <= s_data, out_src <= s, out_valid <= 1.
  - Latency is 1 cycle from input handshake to out_valid.
- No transfer but out_ready & out_valid: out_valid <= 0; out_data and out_src hold their values.
- No transfer and !out_ready: the slot holds. out_data and out_src must stay stable while out_valid=1 and out_ready=0.
- Burst counter, updated on a transfer from s:
  - If s==owner and cnt!=0: cnt <= (cnt==BURST-1) ? 0 : cnt+1.
  - Otherwise: cnt <= (BURST>1) ? 1 : 0.
  - Always: owner <= s.
  - With BURST=1, cnt stays 0 and the block is a strict alternating round-robin.
- Boundary conditions:
  - Owner drops valid mid-burst: the grant moves to the other source immediately, and the burst restarts for that source.
  - Only one source is active: it gets every beat, regardless of owner or cnt.
  - A source must hold valid and data stable until its ready is seen; the arbiter does not latch unaccepted beats.
- Width rule: cnt width is max(1, clog2(BURST)).

Decomposition:
- Shared package: source-id constants SRC_A=0 and SRC_B=1, plus a clog2 helper function for cnt sizing.
- One natural sub-module: rr_grant_2, which is purely combinational.
  - Inputs: a_valid, b_valid, owner, cnt, load_en.
  - Output: grant.
  - Unit-tested separately.
- The top level holds owner, cnt and the output slot. The payload select is a 2:1 mux on grant.

Test Plan:
1. Reset mid-stream: assert rst while out_valid=1 -> out_valid, out_data and out_src drop to 0 in the same cycle. After release, a contention with both valid grants A first.
2. BURST=1, both sources always valid, out_ready=1, A sends 0x11,0x12,0x13 and B sends 0x21,0x22 -> out_data is 0x11,0x21,0x12,0x22,0x13. out_src toggles 0,1,0,1,0. One beat per cycle, with first out_valid 1 cycle after the first handshake.
3. BURST=3, both sources always valid -> out_src sequence is 0,0,0,1,1,1,0,0,0.
4. BURST=3, A drops valid after 1 beat while B is valid -> the next beat comes from B (out_src=1), then B keeps the grant for 3 beats.
5. Backpressure: hold out_ready=0 for 4 cycles with the slot full -> a_ready=b_ready=0, and out_data/out_src stay stable. When out_ready=1, the drain and a new load occur in the same cycle.
6. Only B valid with data 0xAA,0xAB and owner=B -> both beats are accepted back-to-back, out_src=1 each time, and a_ready stays 0.
